// File: rtl/fp_pkg.sv
// Shared definitions for the IEEE-754 arithmetic pipelines: default format,
// operand classes, exception flag bundle and the canonical quiet NaN pattern.
package fp_pkg;

  localparam int unsigned FP_EXP_W   = 8;
  localparam int unsigned FP_MAN_W   = 23;
  localparam int unsigned FP_BIAS    = (1 << (FP_EXP_W - 1)) - 1;
  localparam int unsigned FP_EXP_MAX = (1 << FP_EXP_W) - 1;
  localparam int unsigned FP_WIDTH   = FP_EXP_W + FP_MAN_W + 1;
  localparam int unsigned FP_MAX_W   = 128;

  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,
    CLS_NORM = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } fp_class_e;

  typedef struct packed {
    logic overflow;
    logic underflow;
    logic invalid;
    logic inexact;
  } fp_flags_t;

  // Positive sign, all-ones exponent, only the fraction MSB set; callers truncate to their width.
  function automatic logic [FP_MAX_W-1:0] canon_qnan(input int unsigned exp_w,
                                                      input int unsigned man_w);
    logic [FP_MAX_W-1:0] one;
    one = {{(FP_MAX_W-1){1'b0}}, 1'b1};
    return ((one << (exp_w + 1)) - one) << (man_w - 1);
  endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a normalised significand with guard/round/sticky bits.
// A carry out of the significand renormalises it and bumps the exponent.
module fp_round_rne
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = FP_EXP_W,
  parameter int unsigned MAN_W = FP_MAN_W
) (
  input  logic [MAN_W:0]         man_i,
  input  logic                   g_i,
  input  logic                   r_i,
  input  logic                   s_i,
  input  logic signed [EXP_W+1:0] exp_i,
  output logic [MAN_W:0]         man_o,
  output logic signed [EXP_W+1:0] exp_o,
  output logic                   carry_o
);

  logic             inc;
  logic [MAN_W+1:0] sum;

  // Increment on more than half an ulp, or exactly half with an odd lsb.
  always_comb begin
    inc     = g_i & (r_i | s_i | man_i[0]);
    sum     = {1'b0, man_i} + {{(MAN_W+1){1'b0}}, inc};
    carry_o = sum[MAN_W+1];
    if (carry_o) begin
      man_o = sum[MAN_W+1:1];
      exp_o = exp_i + $signed({{(EXP_W+1){1'b0}}, 1'b1});
    end else begin
      man_o = sum[MAN_W:0];
      exp_o = exp_i;
    end
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage IEEE-754 multiplier (classify/multiply, normalise, round/pack) with
// DAZ inputs, FTZ outputs, RNE rounding and a valid/ready stream that stalls as a whole.
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = FP_EXP_W,
  parameter int unsigned MAN_W = FP_MAN_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic                 overflow,
  output logic                 underflow,
  output logic                 invalid,
  output logic                 inexact
);

  localparam int unsigned W       = EXP_W + MAN_W + 1;
  localparam int unsigned BIAS    = (1 << (EXP_W - 1)) - 1;
  localparam int unsigned EXP_MAX = (1 << EXP_W) - 1;
  localparam int unsigned EW      = EXP_W + 2;
  localparam int unsigned PW      = 2 * MAN_W + 2;

  localparam logic [W-1:0]         QNAN      = W'(canon_qnan(EXP_W, MAN_W));
  localparam logic signed [EW-1:0] BIAS_S    = EW'(BIAS);
  localparam logic signed [EW-1:0] EXP_MAX_S = EW'(EXP_MAX);
  localparam logic signed [EW-1:0] ZERO_S    = {EW{1'b0}};

  function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
    fp_class_e c;
    if (e == {EXP_W{1'b0}}) begin
      c = CLS_ZERO;
    end else if (e == {EXP_W{1'b1}}) begin
      c = (f == {MAN_W{1'b0}}) ? CLS_INF : CLS_NAN;
    end else begin
      c = CLS_NORM;
    end
    return c;
  endfunction

  logic advance;
  fp_class_e cls_a, cls_b;

  logic                 s1_valid_d, s1_valid_q, s1_sign_d, s1_sign_q, s1_inv_d, s1_inv_q;
  fp_class_e            s1_cls_d, s1_cls_q;
  logic [PW-1:0]        s1_prod_d, s1_prod_q;
  logic signed [EW-1:0] s1_exp_d, s1_exp_q;

  logic [PW-1:0]        norm;
  logic                 s2_valid_d, s2_valid_q, s2_sign_d, s2_sign_q, s2_inv_d, s2_inv_q;
  fp_class_e            s2_cls_d, s2_cls_q;
  logic [MAN_W:0]       s2_man_d, s2_man_q;
  logic                 s2_g_d, s2_g_q, s2_r_d, s2_r_q, s2_s_d, s2_s_q;
  logic signed [EW-1:0] s2_exp_d, s2_exp_q;

  logic [MAN_W:0]       rnd_man;
  logic signed [EW-1:0] rnd_exp;
  logic                 rnd_carry;
  logic                 unused_rnd;
  logic [W-1:0]         res_nx;
  fp_flags_t            flags_nx;
  logic                 out_valid_d, out_valid_q;
  logic [W-1:0]         result_d, result_q;
  fp_flags_t            flags_d, flags_q;

  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance;

  // Stage 1: classify (subnormals read as zero), resolve specials by priority, multiply significands.
  always_comb begin
    cls_a      = classify(a[W-2:MAN_W], a[MAN_W-1:0]);
    cls_b      = classify(b[W-2:MAN_W], b[MAN_W-1:0]);
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_inv_d   = s1_inv_q;
    s1_cls_d   = s1_cls_q;
    s1_prod_d  = s1_prod_q;
    s1_exp_d   = s1_exp_q;
    if (advance) begin
      s1_valid_d = in_valid;
      s1_sign_d  = a[W-1] ^ b[W-1];
      s1_prod_d  = PW'({1'b1, a[MAN_W-1:0]}) * PW'({1'b1, b[MAN_W-1:0]});
      s1_exp_d   = $signed(EW'(a[W-2:MAN_W])) + $signed(EW'(b[W-2:MAN_W])) - BIAS_S;
      s1_inv_d   = 1'b0;
      if (cls_a == CLS_NAN || cls_b == CLS_NAN) begin
        s1_cls_d = CLS_NAN;
        s1_inv_d = (cls_a == CLS_NAN && !a[MAN_W-1]) || (cls_b == CLS_NAN && !b[MAN_W-1]);
      end else if ((cls_a == CLS_INF && cls_b == CLS_ZERO) ||
                   (cls_a == CLS_ZERO && cls_b == CLS_INF)) begin
        s1_cls_d = CLS_NAN;
        s1_inv_d = 1'b1;
      end else if (cls_a == CLS_INF || cls_b == CLS_INF) begin
        s1_cls_d = CLS_INF;
      end else if (cls_a == CLS_ZERO || cls_b == CLS_ZERO) begin
        s1_cls_d = CLS_ZERO;
      end else begin
        s1_cls_d = CLS_NORM;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Stage 2: bring the product into [1,2) and split off guard/round/sticky.
  always_comb begin
    norm       = s1_prod_q[PW-1] ? s1_prod_q : (s1_prod_q << 1);
    s2_valid_d = s2_valid_q;
    s2_sign_d  = s2_sign_q;
    s2_inv_d   = s2_inv_q;
    s2_cls_d   = s2_cls_q;
    s2_man_d   = s2_man_q;
    s2_g_d     = s2_g_q;
    s2_r_d     = s2_r_q;
    s2_s_d     = s2_s_q;
    s2_exp_d   = s2_exp_q;
    if (advance) begin
      s2_valid_d = s1_valid_q;
      s2_sign_d  = s1_sign_q;
      s2_inv_d   = s1_inv_q;
      s2_cls_d   = s1_cls_q;
      s2_man_d   = norm[PW-1:MAN_W+1];
      s2_g_d     = norm[MAN_W];
      s2_r_d     = norm[MAN_W-1];
      s2_s_d     = |norm[MAN_W-2:0];
      s2_exp_d   = s1_exp_q + $signed({{(EW-1){1'b0}}, s1_prod_q[PW-1]});
    end else begin
      s2_valid_d = s2_valid_q;
    end
  end

  fp_round_rne #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round (
    .man_i  (s2_man_q),
    .g_i    (s2_g_q),
    .r_i    (s2_r_q),
    .s_i    (s2_s_q),
    .exp_i  (s2_exp_q),
    .man_o  (rnd_man),
    .exp_o  (rnd_exp),
    .carry_o(rnd_carry)
  );

  // The hidden bit and carry are already folded into rnd_exp.
  assign unused_rnd = &{1'b0, rnd_man[MAN_W], rnd_carry};

  // Stage 3: pack the rounded value or the special result; an empty slot produces all zeros.
  always_comb begin
    res_nx   = {W{1'b0}};
    flags_nx = '0;
    if (s2_valid_q) begin
      case (s2_cls_q)
        CLS_NAN: begin
          res_nx           = QNAN;
          flags_nx.invalid = s2_inv_q;
        end
        CLS_INF:  res_nx = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        CLS_ZERO: res_nx = {s2_sign_q, {(W-1){1'b0}}};
        CLS_NORM: begin
          if (rnd_exp >= EXP_MAX_S) begin
            res_nx            = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags_nx.overflow = 1'b1;
            flags_nx.inexact  = 1'b1;
          end else if (rnd_exp <= ZERO_S) begin
            res_nx             = {s2_sign_q, {(W-1){1'b0}}};
            flags_nx.underflow = 1'b1;
            flags_nx.inexact   = 1'b1;
          end else begin
            res_nx           = {s2_sign_q, rnd_exp[EXP_W-1:0], rnd_man[MAN_W-1:0]};
            flags_nx.inexact = s2_g_q | s2_r_q | s2_s_q;
          end
        end
        default: res_nx = {W{1'b0}};
      endcase
    end else begin
      res_nx = {W{1'b0}};
    end
    out_valid_d = advance ? s2_valid_q : out_valid_q;
    result_d    = advance ? res_nx : result_q;
    flags_d     = advance ? flags_nx : flags_q;
  end

  // Pipeline registers; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_inv_q    <= 1'b0;
      s1_cls_q    <= CLS_ZERO;
      s1_prod_q   <= {PW{1'b0}};
      s1_exp_q    <= {EW{1'b0}};
      s2_valid_q  <= 1'b0;
      s2_sign_q   <= 1'b0;
      s2_inv_q    <= 1'b0;
      s2_cls_q    <= CLS_ZERO;
      s2_man_q    <= {(MAN_W+1){1'b0}};
      s2_g_q      <= 1'b0;
      s2_r_q      <= 1'b0;
      s2_s_q      <= 1'b0;
      s2_exp_q    <= {EW{1'b0}};
      out_valid_q <= 1'b0;
      result_q    <= {W{1'b0}};
      flags_q     <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sign_q   <= s1_sign_d;
      s1_inv_q    <= s1_inv_d;
      s1_cls_q    <= s1_cls_d;
      s1_prod_q   <= s1_prod_d;
      s1_exp_q    <= s1_exp_d;
      s2_valid_q  <= s2_valid_d;
      s2_sign_q   <= s2_sign_d;
      s2_inv_q    <= s2_inv_d;
      s2_cls_q    <= s2_cls_d;
      s2_man_q    <= s2_man_d;
      s2_g_q      <= s2_g_d;
      s2_r_q      <= s2_r_d;
      s2_s_q      <= s2_s_d;
      s2_exp_q    <= s2_exp_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign overflow  = flags_q.overflow;
  assign underflow = flags_q.underflow;
  assign invalid   = flags_q.invalid;
  assign inexact   = flags_q.inexact;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed bench for fp_mul_pipe in single precision; flags are shown as {ovf,unf,inv,inx}.
module tb_fp_mul_pipe;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic        overflow, underflow, invalid, inexact;
  logic [31:0] a, b, result;
  logic [3:0]  flags;
  int          tests = 0;
  int          fails = 0;

  logic [31:0] va [0:5];
  logic [31:0] vb [0:5];
  logic [31:0] vr [0:5];
  logic [3:0]  vf [0:5];

  assign flags = {overflow, underflow, invalid, inexact};

  always #5 clk = ~clk;

  fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .overflow (overflow),
    .underflow(underflow),
    .invalid  (invalid),
    .inexact  (inexact)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one operation and reports what came out and after how many edges (-1 on timeout).
  task automatic do_op(input logic [31:0] opa, input logic [31:0] opb,
                       output logic [31:0] r, output logic [3:0] f, output int lat);
    int c;
    in_valid  = 1'b1;
    a         = opa;
    b         = opb;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    c = 1;
    while (!out_valid && c < 8) begin
      step();
      c++;
    end
    if (out_valid) begin
      lat = c;
      r   = result;
      f   = flags;
    end else begin
      lat = -1;
      r   = 32'h0;
      f   = 4'h0;
    end
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = 32'h0; b = 32'h0;
    repeat (3) step();
    rst = 1'b0;
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b expected 0", out_valid); end
    tests++; if (result !== 32'h0) begin fails++; $display("FAIL reset_result got %08h expected 00000000", result); end
    tests++; if (flags !== 4'h0) begin fails++; $display("FAIL reset_flags got %b expected 0000", flags); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b expected 1", in_ready); end
  endtask

  task automatic run_table(input string tag, input int n);
    logic [31:0] r;
    logic [3:0]  f;
    int          lat;
    for (int i = 0; i < n; i++) begin
      do_op(va[i], vb[i], r, f, lat);
      tests++; if (lat != 3) begin fails++; $display("FAIL %s[%0d] latency got %0d expected 3", tag, i, lat); end
      tests++; if (r !== vr[i]) begin fails++; $display("FAIL %s[%0d] result got %08h expected %08h", tag, i, r, vr[i]); end
      tests++; if (f !== vf[i]) begin fails++; $display("FAIL %s[%0d] flags got %b expected %b", tag, i, f, vf[i]); end
    end
  endtask

  task automatic test_rounding();
    va = '{32'h3FC00000, 32'h3FC00000, 32'h3F800001, 32'hBF800000, 32'h0, 32'h0};
    vb = '{32'h40000000, 32'h3F800001, 32'h3F800001, 32'h40000000, 32'h0, 32'h0};
    vr = '{32'h40400000, 32'h3FC00002, 32'h3F800002, 32'hC0000000, 32'h0, 32'h0};
    vf = '{4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    run_table("rounding", 4);
  endtask

  task automatic test_range();
    va = '{32'h7F7FFFFF, 32'h00800000, 32'h0, 32'h0, 32'h0, 32'h0};
    vb = '{32'h40000000, 32'h3F000000, 32'h0, 32'h0, 32'h0, 32'h0};
    vr = '{32'h7F800000, 32'h00000000, 32'h0, 32'h0, 32'h0, 32'h0};
    vf = '{4'b1001, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    run_table("range", 2);
  endtask

  task automatic test_specials();
    va = '{32'h7F800000, 32'hFF800000, 32'h7FA00000, 32'h00000001, 32'h7FC00001, 32'h80000000};
    vb = '{32'h00000000, 32'h40000000, 32'h3F800000, 32'h7F000000, 32'h3F800000, 32'h40000000};
    vr = '{32'h7FC00000, 32'hFF800000, 32'h7FC00000, 32'h00000000, 32'h7FC00000, 32'h80000000};
    vf = '{4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
    run_table("specials", 6);
  endtask

  task automatic test_back_to_back();
    int          issued, got;
    logic        stall, xfer, held_v;
    logic [31:0] held;
    va = '{32'h3F800000, 32'h3FC00000, 32'h40000000, 32'h40400000, 32'hBF800000, 32'h3FC00000};
    vb = '{32'h3F800000, 32'h40000000, 32'h40000000, 32'h3F000000, 32'h40000000, 32'h3FC00000};
    vr = '{32'h3F800000, 32'h40400000, 32'h40800000, 32'h3FC00000, 32'hC0000000, 32'h40100000};
    issued = 0; got = 0; held_v = 1'b0; held = 32'h0;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      stall     = (cyc >= 4 && cyc <= 7);
      out_ready = !stall;
      in_valid  = (issued < 6);
      if (issued < 6) begin a = va[issued]; b = vb[issued]; end
      #1;
      tests++; if (in_ready !== !stall) begin fails++; $display("FAIL bp_in_ready cycle %0d got %b expected %b", cyc, in_ready, !stall); end
      if (cyc == 4) begin
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_first_valid got %b expected 1", out_valid); end
      end
      if (out_valid) begin
        if (held_v) begin
          tests++; if (result !== held) begin fails++; $display("FAIL bp_stable cycle %0d got %08h expected %08h", cyc, result, held); end
        end
        if (out_ready) begin
          tests++;
          if (got >= 6) begin fails++; $display("FAIL bp_extra cycle %0d got %08h expected no output", cyc, result); end
          else if (result !== vr[got]) begin fails++; $display("FAIL bp_result[%0d] got %08h expected %08h", got, result, vr[got]); end
          got++;
          held_v = 1'b0;
        end else begin
          held   = result;
          held_v = 1'b1;
        end
      end
      xfer = in_valid && in_ready;
      step();
      if (xfer) issued++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tests++; if (got != 6) begin fails++; $display("FAIL bp_count got %0d expected 6", got); end
  endtask

  task automatic test_reset_flush();
    logic [31:0] r;
    logic [3:0]  f;
    int          lat;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = 32'h7F7FFFFF; b = 32'h40000000; step();
    a = 32'h00800000; b = 32'h3F000000; step();
    a = 32'h7F800000; b = 32'h00000000; step();
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL flush_pre_valid got %b expected 1", out_valid); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_out_valid got %b expected 0", out_valid); end
    tests++; if (flags !== 4'h0) begin fails++; $display("FAIL flush_flags got %b expected 0000", flags); end
    tests++; if (result !== 32'h0) begin fails++; $display("FAIL flush_result got %08h expected 00000000", result); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL flush_in_ready got %b expected 1", in_ready); end
    for (int i = 0; i < 4; i++) begin
      step();
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_ghost cycle %0d got %b expected 0", i, out_valid); end
    end
    do_op(32'h3FC00000, 32'h40000000, r, f, lat);
    tests++; if (lat != 3) begin fails++; $display("FAIL flush_new_latency got %0d expected 3", lat); end
    tests++; if (r !== 32'h40400000) begin fails++; $display("FAIL flush_new_result got %08h expected 40400000", r); end
    tests++; if (f !== 4'h0) begin fails++; $display("FAIL flush_new_flags got %b expected 0000", f); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = 32'h0; b = 32'h0;
    test_reset();
    test_rounding();
    test_range();
    test_specials();
    test_back_to_back();
    test_reset_flush();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t with %0d tests run", $time, tests);
    $fatal(1, "simulation time limit reached");
  end

endmodule
